// File: rtl/uop_sequencer.sv
// Micro-op sequencer: captures 1-3 uops per instruction from decode and
// issues them one per cycle (uop_2 -> uop_1 -> uop_0) to the execute stage.
module uop_sequencer #(
  parameter int UOP_W = 20
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             hold,
  input  logic             flush,
  output logic             feed_req,
  input  logic             feed_ack,
  input  logic [UOP_W-1:0] uop_0_in,
  input  logic [UOP_W-1:0] uop_1_in,
  input  logic [UOP_W-1:0] uop_2_in,
  input  logic [1:0]       uop_count,
  input  logic             exec_ready,
  output logic [UOP_W-1:0] uop_out,
  output logic             uop_valid,
  output logic             uop_last,
  output logic [1:0]       uop_idx
);

  logic [UOP_W-1:0] slot0_r;
  logic [UOP_W-1:0] slot1_r;
  logic [UOP_W-1:0] slot2_r;
  logic [1:0]       idx_r;
  logic             busy_r;

  logic             xfer_s;
  logic             last_s;
  logic             capture_s;
  logic [1:0]       start_idx_s;

  // Handshake terms; feed_req must never depend on feed_ack.
  always_comb begin
    last_s      = busy_r & (idx_r == 2'd0);
    xfer_s      = busy_r & exec_ready & ~hold;
    feed_req    = ~hold & ~flush & (~busy_r | (xfer_s & last_s));
    capture_s   = feed_ack & feed_req;
    start_idx_s = (uop_count == 2'd3) ? 2'd2 : uop_count;
  end

  // Output view of the current slot, driven from registers only.
  always_comb begin
    case (idx_r)
      2'd0:    uop_out = slot0_r;
      2'd1:    uop_out = slot1_r;
      2'd2:    uop_out = slot2_r;
      default: uop_out = {UOP_W{1'b0}};
    endcase
    uop_valid = busy_r;
    uop_last  = last_s;
    uop_idx   = idx_r;
  end

  // Sequencer state: flush beats capture, capture beats advance; hold freezes all.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      slot0_r <= {UOP_W{1'b0}};
      slot1_r <= {UOP_W{1'b0}};
      slot2_r <= {UOP_W{1'b0}};
      idx_r   <= 2'd0;
      busy_r  <= 1'b0;
    end else if (!hold) begin
      if (flush) begin
        idx_r  <= 2'd0;
        busy_r <= 1'b0;
      end else if (capture_s) begin
        slot0_r <= uop_0_in;
        slot1_r <= uop_1_in;
        slot2_r <= uop_2_in;
        idx_r   <= start_idx_s;
        busy_r  <= 1'b1;
      end else if (xfer_s) begin
        if (idx_r != 2'd0) begin
          idx_r <= idx_r - 2'd1;
        end else begin
          busy_r <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uop_sequencer.sv
// Directed self-checking bench for uop_sequencer.
module tb_uop_sequencer;

  localparam int UOP_W = 20;

  logic             clk;
  logic             a_rst;
  logic             hold;
  logic             flush;
  logic             feed_req;
  logic             feed_ack;
  logic [UOP_W-1:0] uop_0_in;
  logic [UOP_W-1:0] uop_1_in;
  logic [UOP_W-1:0] uop_2_in;
  logic [1:0]       uop_count;
  logic             exec_ready;
  logic [UOP_W-1:0] uop_out;
  logic             uop_valid;
  logic             uop_last;
  logic [1:0]       uop_idx;

  int checks = 0;
  int errors = 0;

  localparam logic [UOP_W-1:0] VA = 20'hA1A1A;
  localparam logic [UOP_W-1:0] VB = 20'hB2B2B;
  localparam logic [UOP_W-1:0] VC = 20'hC3C3C;
  localparam logic [UOP_W-1:0] VE = 20'hE5E5E;

  uop_sequencer #(.UOP_W(UOP_W)) dut (
    .clk        (clk),
    .a_rst      (a_rst),
    .hold       (hold),
    .flush      (flush),
    .feed_req   (feed_req),
    .feed_ack   (feed_ack),
    .uop_0_in   (uop_0_in),
    .uop_1_in   (uop_1_in),
    .uop_2_in   (uop_2_in),
    .uop_count  (uop_count),
    .exec_ready (exec_ready),
    .uop_out    (uop_out),
    .uop_valid  (uop_valid),
    .uop_last   (uop_last),
    .uop_idx    (uop_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Inputs settle, then sample combinational feed_req and registered outputs.
  task automatic look(input string tag, input logic v, input logic l, input logic [1:0] i,
                      input logic [UOP_W-1:0] o, input logic fr);
    #1;
    check({tag, "_valid"}, {31'd0, uop_valid}, {31'd0, v});
    check({tag, "_last"}, {31'd0, uop_last}, {31'd0, l});
    check({tag, "_idx"}, {30'd0, uop_idx}, {30'd0, i});
    if (v) check({tag, "_out"}, {12'd0, uop_out}, {12'd0, o});
    check({tag, "_req"}, {31'd0, feed_req}, {31'd0, fr});
  endtask

  initial begin
    a_rst = 1'b0; hold = 1'b0; flush = 1'b0; feed_ack = 1'b0;
    uop_0_in = '0; uop_1_in = '0; uop_2_in = '0; uop_count = 2'd0; exec_ready = 1'b1;
    #2;
    check("rst_out", {12'd0, uop_out}, 32'd0);
    check("rst_valid", {31'd0, uop_valid}, 32'd0);
    check("rst_idx", {30'd0, uop_idx}, 32'd0);
    next();
    a_rst = 1'b1;
    look("post_rst", 1'b0, 1'b0, 2'd0, '0, 1'b1);

    // 3-uop instruction A/B/C
    uop_0_in = VA; uop_1_in = VB; uop_2_in = VC; uop_count = 2'd2; feed_ack = 1'b1;
    next();
    feed_ack = 1'b0;
    look("t1_n1", 1'b1, 1'b0, 2'd2, VC, 1'b0);
    next();
    look("t1_n2", 1'b1, 1'b0, 2'd1, VB, 1'b0);
    next();
    look("t1_n3", 1'b1, 1'b1, 2'd0, VA, 1'b1);
    next();
    look("t1_end", 1'b0, 1'b0, 2'd0, '0, 1'b1);

    // back-to-back single-uop stream
    uop_count = 2'd0; uop_0_in = 20'h10000; feed_ack = 1'b1;
    next();
    for (int i = 1; i <= 4; i++) begin
      uop_0_in = 20'h10000 + 20'(i);
      look("t2_stream", 1'b1, 1'b1, 2'd0, 20'h10000 + 20'(i - 1), 1'b1);
      next();
    end
    feed_ack = 1'b0;
    look("t2_tail", 1'b1, 1'b1, 2'd0, 20'h10004, 1'b1);
    next();
    look("t2_end", 1'b0, 1'b0, 2'd0, '0, 1'b1);

    // 2-uop with exec_ready stall on idx 1, spurious ack during stall
    uop_0_in = VA; uop_1_in = VB; uop_2_in = VC; uop_count = 2'd1; feed_ack = 1'b1;
    next();
    feed_ack = 1'b0; exec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      feed_ack = 1'b1; uop_1_in = VE; uop_count = 2'd2;
      look("t3_stall", 1'b1, 1'b0, 2'd1, VB, 1'b0);
      next();
    end
    feed_ack = 1'b0; uop_1_in = VB; uop_count = 2'd1; exec_ready = 1'b1;
    look("t3_resume", 1'b1, 1'b0, 2'd1, VB, 1'b0);
    next();
    look("t3_last", 1'b1, 1'b1, 2'd0, VA, 1'b1);
    next();
    look("t3_end", 1'b0, 1'b0, 2'd0, '0, 1'b1);

    // hold for two cycles on idx 1; flush while held is ignored
    feed_ack = 1'b1;
    next();
    feed_ack = 1'b0; hold = 1'b1;
    look("t4_hold1", 1'b1, 1'b0, 2'd1, VB, 1'b0);
    next();
    flush = 1'b1;
    look("t4_hold2", 1'b1, 1'b0, 2'd1, VB, 1'b0);
    next();
    hold = 1'b0; flush = 1'b0;
    look("t4_rel", 1'b1, 1'b0, 2'd1, VB, 1'b0);
    next();
    look("t4_last", 1'b1, 1'b1, 2'd0, VA, 1'b1);
    next();
    look("t4_end", 1'b0, 1'b0, 2'd0, '0, 1'b1);

    // flush during idx 2 with a spurious ack
    uop_count = 2'd2; feed_ack = 1'b1;
    next();
    feed_ack = 1'b1; flush = 1'b1; uop_count = 2'd0; uop_0_in = VE;
    look("t5_flush", 1'b1, 1'b0, 2'd2, VC, 1'b0);
    next();
    feed_ack = 1'b0; flush = 1'b0;
    look("t5_after", 1'b0, 1'b0, 2'd0, '0, 1'b1);
    next();
    look("t5_quiet", 1'b0, 1'b0, 2'd0, '0, 1'b1);

    // uop_count 3 clamps to 2, then async reset mid-sequence
    uop_0_in = VA; uop_1_in = VB; uop_2_in = VC; uop_count = 2'd3; feed_ack = 1'b1;
    next();
    feed_ack = 1'b0;
    look("t6_n1", 1'b1, 1'b0, 2'd2, VC, 1'b0);
    next();
    look("t6_n2", 1'b1, 1'b0, 2'd1, VB, 1'b0);
    #1;
    a_rst = 1'b0;
    #1;
    check("t6_rst_out", {12'd0, uop_out}, 32'd0);
    check("t6_rst_valid", {31'd0, uop_valid}, 32'd0);
    check("t6_rst_last", {31'd0, uop_last}, 32'd0);
    check("t6_rst_idx", {30'd0, uop_idx}, 32'd0);
    #1;
    a_rst = 1'b1;
    look("t6_rel", 1'b0, 1'b0, 2'd0, '0, 1'b1);
    next();
    look("t6_empty", 1'b0, 1'b0, 2'd0, '0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
